// File: rtl/bus_cycle_engine.sv
// bus_cycle_engine
// Runs one MC-style bus transfer per request. Supported sizes are byte, word and long.
// A long transfer is executed as two word cycles: the high word first, then the low word.
// All bus timing is paced by one-sys_clk strobes that mark the MC clock edges.
//
// Handshake: a req_start pulse is accepted only in IDLE. req_busy is high from the
// next cycle until the cycle that carries the single-cycle req_done pulse.
// req_terminated_normally is updated on every finish and holds until the next one.
//
// Optional feature, macro BERR_TIMEOUT_EN: an 8-bit counter of MC falling edges in
// WAIT_DTACK. On the 255th edge without DTACK the transfer ends as a bus error.
// Without the macro the engine waits for DTACK or BERR indefinitely.
// dbg_state exposes the FSM state for checkers.
module bus_cycle_engine (
  input  logic        sys_clk,
  input  logic        nRST,
  input  logic        mc_clk_rising,
  input  logic        mc_clk_falling,
  input  logic        req_start,
  input  logic [23:0] req_address,
  input  logic [1:0]  req_size,
  input  logic        req_rw,
  input  logic [2:0]  req_fc,
  input  logic [31:0] req_data_write,
  input  logic        dtack_n,
  input  logic        berr_n,
  input  logic [15:0] d_in,
  output logic [22:0] a_out,
  output logic [15:0] d_out,
  output logic [2:0]  fc_out,
  output logic        rnw_out,
  output logic        nas_out,
  output logic        nuds_out,
  output logic        nlds_out,
  output logic        abus_drive,
  output logic        dbus_drive,
  output logic        ctrl_drive,
  output logic [31:0] req_data_read,
  output logic        req_busy,
  output logic        req_done,
  output logic        req_terminated_normally,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_S0    = 3'd1,
    ST_WAIT_AS    = 3'd2,
    ST_WAIT_DS    = 3'd3,
    ST_WAIT_DTACK = 3'd4,
    ST_LATCH      = 3'd5,
    ST_END        = 3'd6
  } state_t;

  state_t      state_q, state_d;

  // Latched request
  logic [23:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        rw_q, rw_d;
  logic [2:0]  fc_q, fc_d;
  logic [31:0] wdata_q, wdata_d;
  logic        second_q, second_d;   // working on the low word of a long
  logic        err_q, err_d;         // current transfer ended by bus error

  // Bus and status registers
  logic [22:0] a_q, a_d;
  logic [15:0] dout_q, dout_d;
  logic [2:0]  fcout_q, fcout_d;
  logic        rnw_q, rnw_d;
  logic        nas_q, nas_d;
  logic        nuds_q, nuds_d;
  logic        nlds_q, nlds_d;
  logic        abus_q, abus_d;
  logic        dbus_q, dbus_d;
  logic        ctrl_q, ctrl_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tnorm_q, tnorm_d;

  logic        timeout_hit;

`ifdef BERR_TIMEOUT_EN
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  // 254 edges already counted means the current edge is the 255th
  assign timeout_hit = (tmo_cnt_q == 8'd254);
`else
  assign timeout_hit = 1'b0;
`endif

  // Derived transfer attributes
  logic        is_byte, is_long;
  logic [22:0] word_addr;      // A23..A1 of the word currently being transferred
  logic        sel_uds, sel_lds;
  logic [15:0] wr_word;
  logic [31:0] rd_merge;

  assign is_byte   = (size_q == 2'd0);
  assign is_long   = (size_q == 2'd2);
  // address + 2 with 24-bit wrap leaves A0 untouched and increments A23..A1
  assign word_addr = second_q ? (addr_q[23:1] + 23'd1) : addr_q[23:1];
  assign sel_uds   = !is_byte || !addr_q[0];
  assign sel_lds   = !is_byte ||  addr_q[0];

  // Byte writes replicate the byte so it is valid on whichever lane is strobed
  assign wr_word = is_byte ? {wdata_q[7:0], wdata_q[7:0]} :
                   (is_long && !second_q) ? wdata_q[31:16] : wdata_q[15:0];

  // Merge the captured bus word into the read-data register
  always_comb begin
    rd_merge = {16'd0, d_in};
    if (is_byte) begin
      rd_merge = {24'd0, (addr_q[0] ? d_in[7:0] : d_in[15:8])};
    end else if (is_long) begin
      rd_merge = second_q ? {rdata_q[31:16], d_in} : {d_in, rdata_q[15:0]};
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    rw_d     = rw_q;
    fc_d     = fc_q;
    wdata_d  = wdata_q;
    second_d = second_q;
    err_d    = err_q;
    a_d      = a_q;
    dout_d   = dout_q;
    fcout_d  = fcout_q;
    rnw_d    = rnw_q;
    nas_d    = nas_q;
    nuds_d   = nuds_q;
    nlds_d   = nlds_q;
    abus_d   = abus_q;
    dbus_d   = dbus_q;
    ctrl_d   = ctrl_q;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tnorm_d  = tnorm_q;
`ifdef BERR_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_start) begin
          addr_d   = req_address;
          size_d   = req_size;
          rw_d     = req_rw;
          fc_d     = req_fc;
          wdata_d  = req_data_write;
          second_d = 1'b0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_WAIT_S0;
        end
      end

      ST_WAIT_S0: begin
        if (mc_clk_rising) begin
          a_d     = word_addr;
          fcout_d = fc_q;
          rnw_d   = rw_q;
          abus_d  = 1'b1;
          ctrl_d  = 1'b1;
          state_d = ST_WAIT_AS;
        end
      end

      ST_WAIT_AS: begin
        if (mc_clk_falling) begin
          nas_d = 1'b0;
          if (rw_q) begin
            nuds_d  = !sel_uds;
            nlds_d  = !sel_lds;
            state_d = ST_WAIT_DTACK;
`ifdef BERR_TIMEOUT_EN
            tmo_cnt_d = 8'd0;
`endif
          end else begin
            dbus_d  = 1'b1;
            dout_d  = wr_word;
            state_d = ST_WAIT_DS;
          end
        end
      end

      ST_WAIT_DS: begin
        if (mc_clk_falling) begin
          nuds_d  = !sel_uds;
          nlds_d  = !sel_lds;
          state_d = ST_WAIT_DTACK;
`ifdef BERR_TIMEOUT_EN
          tmo_cnt_d = 8'd0;
`endif
        end
      end

      ST_WAIT_DTACK: begin
        if (mc_clk_falling) begin
          if (!berr_n || (dtack_n && timeout_hit)) begin
            err_d   = 1'b1;
            nas_d   = 1'b1;
            nuds_d  = 1'b1;
            nlds_d  = 1'b1;
            state_d = ST_END;
          end else if (!dtack_n) begin
            state_d = ST_LATCH;
          end else begin
`ifdef BERR_TIMEOUT_EN
            tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
          end
        end
      end

      ST_LATCH: begin
        if (mc_clk_falling) begin
          if (rw_q) begin
            rdata_d = rd_merge;
          end
          nas_d   = 1'b1;
          nuds_d  = 1'b1;
          nlds_d  = 1'b1;
          state_d = ST_END;
        end
      end

      ST_END: begin
        if (mc_clk_rising) begin
          dbus_d = 1'b0;
          if (is_long && !second_q && !err_q) begin
            // This rising edge doubles as S0 of the low word: the address is
            // presented here and the engine waits directly for the AS edge.
            second_d = 1'b1;
            a_d      = addr_q[23:1] + 23'd1;
            state_d  = ST_WAIT_AS;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            abus_d  = 1'b0;
            ctrl_d  = 1'b0;
            tnorm_d = !err_q;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request, bus and status registers
  always_ff @(posedge sys_clk or negedge nRST) begin
    if (!nRST) begin
      addr_q   <= '0;
      size_q   <= '0;
      rw_q     <= 1'b1;
      fc_q     <= '0;
      wdata_q  <= '0;
      second_q <= 1'b0;
      err_q    <= 1'b0;
      a_q      <= '0;
      dout_q   <= '0;
      fcout_q  <= '0;
      rnw_q    <= 1'b1;
      nas_q    <= 1'b1;
      nuds_q   <= 1'b1;
      nlds_q   <= 1'b1;
      abus_q   <= 1'b0;
      dbus_q   <= 1'b0;
      ctrl_q   <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tnorm_q  <= 1'b0;
`ifdef BERR_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      addr_q   <= addr_d;
      size_q   <= size_d;
      rw_q     <= rw_d;
      fc_q     <= fc_d;
      wdata_q  <= wdata_d;
      second_q <= second_d;
      err_q    <= err_d;
      a_q      <= a_d;
      dout_q   <= dout_d;
      fcout_q  <= fcout_d;
      rnw_q    <= rnw_d;
      nas_q    <= nas_d;
      nuds_q   <= nuds_d;
      nlds_q   <= nlds_d;
      abus_q   <= abus_d;
      dbus_q   <= dbus_d;
      ctrl_q   <= ctrl_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tnorm_q  <= tnorm_d;
`ifdef BERR_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign a_out                   = a_q;
  assign d_out                   = dout_q;
  assign fc_out                  = fcout_q;
  assign rnw_out                 = rnw_q;
  assign nas_out                 = nas_q;
  assign nuds_out                = nuds_q;
  assign nlds_out                = nlds_q;
  assign abus_drive              = abus_q;
  assign dbus_drive              = dbus_q;
  assign ctrl_drive              = ctrl_q;
  assign req_data_read           = rdata_q;
  assign req_busy                = busy_q;
  assign req_done                = done_q;
  assign req_terminated_normally = tnorm_q;
  assign dbg_state               = state_q;

endmodule

// File: tb/tb_bus_cycle_engine.sv
// tb_bus_cycle_engine
// Directed bench for bus_cycle_engine: a strobe generator, a bus responder with a
// programmable DTACK/BERR delay, driver tasks, and a scoreboard of expected
// {terminated_normally, read_data} popped on every req_done.
// Honours BERR_TIMEOUT_EN for the no-DTACK scenario.
`timescale 1ns/1ps
module tb_bus_cycle_engine;

  logic        sys_clk = 1'b0;
  logic        nRST;
  logic        mc_clk_rising, mc_clk_falling;
  logic        req_start;
  logic [23:0] req_address;
  logic [1:0]  req_size;
  logic        req_rw;
  logic [2:0]  req_fc;
  logic [31:0] req_data_write;
  logic        dtack_n, berr_n;
  logic [15:0] d_in;
  logic [22:0] a_out;
  logic [15:0] d_out;
  logic [2:0]  fc_out;
  logic        rnw_out, nas_out, nuds_out, nlds_out;
  logic        abus_drive, dbus_drive, ctrl_drive;
  logic [31:0] req_data_read;
  logic        req_busy, req_done, req_terminated_normally;
  logic [2:0]  dbg_state;

  bus_cycle_engine dut (
    .sys_clk(sys_clk), .nRST(nRST),
    .mc_clk_rising(mc_clk_rising), .mc_clk_falling(mc_clk_falling),
    .req_start(req_start), .req_address(req_address), .req_size(req_size),
    .req_rw(req_rw), .req_fc(req_fc), .req_data_write(req_data_write),
    .dtack_n(dtack_n), .berr_n(berr_n), .d_in(d_in),
    .a_out(a_out), .d_out(d_out), .fc_out(fc_out), .rnw_out(rnw_out),
    .nas_out(nas_out), .nuds_out(nuds_out), .nlds_out(nlds_out),
    .abus_drive(abus_drive), .dbus_drive(dbus_drive), .ctrl_drive(ctrl_drive),
    .req_data_read(req_data_read), .req_busy(req_busy), .req_done(req_done),
    .req_terminated_normally(req_terminated_normally), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / MC strobes ----------------
  initial forever #5 sys_clk = ~sys_clk;

  // MC clock period = 8 sys_clk: rising strobe at phase 0, falling at phase 4
  initial begin
    int phase;
    phase = 0;
    mc_clk_rising  = 1'b0;
    mc_clk_falling = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      mc_clk_rising  = (phase == 0);
      mc_clk_falling = (phase == 4);
      phase = (phase + 1) % 8;
    end
  end

  // ---------------- bus responder ----------------
  int          dtk_dly = 0;   // DTACK seen on the Nth MC fall after AS; 0 = never
  int          berr_dly = 0;
  logic [15:0] w0 = 16'h0, w1 = 16'h0;
  int          as_falls = 0;
  int          as_cnt = 0;
  int          fall_cnt = 0;
  logic        nas_prev = 1'b1;

  always @(posedge sys_clk) begin
    if (mc_clk_falling) fall_cnt <= fall_cnt + 1;
    if (!nas_out) as_falls <= as_falls + (mc_clk_falling ? 1 : 0);
    else          as_falls <= 0;
    nas_prev <= nas_out;
    if (req_start && !req_busy)   as_cnt <= 0;
    else if (!nas_prev && nas_out) as_cnt <= as_cnt + 1;
  end

  assign dtack_n = !(dtk_dly != 0 && !nas_out && as_falls >= dtk_dly - 1);
  assign berr_n  = !(berr_dly != 0 && !nas_out && as_falls >= berr_dly - 1);
  assign d_in    = (as_cnt == 0) ? w0 : w1;

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];   // {terminated_normally, req_data_read}

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Observer and scoreboard monitor
  int          obs_as_n = 0, obs_done_n = 0, obs_as_at = 0, obs_ds_at = 0;
  logic [22:0] obs_a [2];
  logic        obs_uds = 1'b0, obs_lds = 1'b0, obs_ds_seen = 1'b0, obs_nas_prev = 1'b1;
  logic        obs_rnw = 1'b1;
  logic [2:0]  obs_fc = 3'd0;
  logic [15:0] obs_dout = 16'h0;

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge sys_clk);
      if (req_start && !req_busy) begin
        obs_as_n = 0; obs_done_n = 0; obs_uds = 1'b0; obs_lds = 1'b0; obs_ds_seen = 1'b0;
      end
      if (!nas_out && obs_nas_prev) begin
        if (obs_as_n < 2) obs_a[obs_as_n] = a_out;
        obs_as_at = fall_cnt;
        obs_rnw   = rnw_out;
        obs_fc    = fc_out;
        obs_as_n++;
      end
      if ((!nuds_out || !nlds_out) && !obs_ds_seen) begin
        obs_ds_seen = 1'b1;
        obs_ds_at   = fall_cnt;
        obs_dout    = d_out;
      end
      if (!nuds_out) obs_uds = 1'b1;
      if (!nlds_out) obs_lds = 1'b1;
      if (!nas_out || !nuds_out || !nlds_out) check("strobe_needs_abus", 32'(abus_drive), 32'd1);
      if (req_done) begin
        obs_done_n++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done with data %h, expected none", req_data_read);
        end else begin
          e = exp_q.pop_front();
          check("read_data", req_data_read, e[31:0]);
          check("term_normally", 32'(req_terminated_normally), 32'(e[32]));
        end
      end
      obs_nas_prev = nas_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [23:0] a, input logic [1:0] sz, input logic rw,
                       input logic [2:0] fc, input logic [31:0] wd);
    @(posedge sys_clk); #1;
    req_address = a; req_size = sz; req_rw = rw; req_fc = fc; req_data_write = wd;
    req_start = 1'b1;
    @(posedge sys_clk); #1;
    req_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (req_busy !== 1'b0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (req_busy !== 1'b0) begin
      total++; bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, budget);
    end
    @(negedge sys_clk);
  endtask

  task automatic pulse_reset();
    @(negedge sys_clk); #1;
    nRST = 1'b0;
    repeat (3) @(negedge sys_clk);
    nRST = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, f0;
    nRST = 1'b0; req_start = 1'b0; req_address = '0; req_size = '0;
    req_rw = 1'b1; req_fc = '0; req_data_write = '0;
    repeat (4) @(negedge sys_clk);

    // Reset state
    check("rst_strobes_rnw", 32'({nas_out, nuds_out, nlds_out, rnw_out}), 32'hF);
    check("rst_drives", 32'({abus_drive, dbus_drive, ctrl_drive}), 32'h0);
    check("rst_status", 32'({req_busy, req_done, req_terminated_normally}), 32'h0);
    check("rst_rdata", req_data_read, 32'h0);
    check("rst_bus", 32'({a_out, fc_out}), 32'h0);
    check("rst_dout", 32'(d_out), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    nRST = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Word read at 0x00F000, DTACK 2 falls after AS
    dtk_dly = 2; berr_dly = 0; w0 = 16'h1234; w1 = 16'h0;
    exp_q.push_back({1'b1, 32'h0000_1234});
    issue(24'h00F000, 2'd1, 1'b1, 3'd5, 32'h0);
    check("word_rd_busy", 32'(req_busy), 32'd1);
    wait_idle("word_rd", 400);
    check("word_rd_as_count", obs_as_n, 1);
    check("word_rd_addr", 32'(obs_a[0]), 32'h0000_7800);
    check("word_rd_fc_rnw", 32'({obs_fc, obs_rnw}), 32'({3'd5, 1'b1}));
    check("word_rd_both_ds", 32'({obs_uds, obs_lds}), 32'h3);
    check("word_rd_ds_with_as", obs_ds_at - obs_as_at, 0);
    check("word_rd_done_once", obs_done_n, 1);
    check("idle_drives", 32'({abus_drive, dbus_drive, ctrl_drive}), 32'h0);

    // Byte write at 0x000003 (odd -> LDS only), read data untouched
    exp_q.push_back({1'b1, 32'h0000_1234});
    issue(24'h000003, 2'd0, 1'b0, 3'd1, 32'h0000_00AB);
    wait_idle("byte_wr", 400);
    check("byte_wr_uds_lds", 32'({obs_uds, obs_lds}), 32'h1);
    check("byte_wr_dout", 32'(obs_dout[7:0]), 32'hAB);
    check("byte_wr_ds_delay", obs_ds_at - obs_as_at, 1);
    check("byte_wr_rnw", 32'(obs_rnw), 32'd0);
    check("byte_wr_addr", 32'(obs_a[0]), 32'h1);

    // Long read at 0xFFFFFE with address wrap on the low word
    w0 = 16'hDEAD; w1 = 16'hBEEF;
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    issue(24'hFFFFFE, 2'd2, 1'b1, 3'd2, 32'h0);
    wait_idle("long_rd", 800);
    check("long_rd_as_count", obs_as_n, 2);
    check("long_rd_addr_hi", 32'(obs_a[0]), 32'h007F_FFFF);
    check("long_rd_addr_lo", 32'(obs_a[1]), 32'h0);

    // Long read where BERR and DTACK arrive together on the first word
    berr_dly = 2; w0 = 16'h1111; w1 = 16'h2222;
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    issue(24'h000100, 2'd2, 1'b1, 3'd2, 32'h0);
    wait_idle("long_berr", 800);
    check("long_berr_one_cycle", obs_as_n, 1);
    berr_dly = 0;

    // Byte read at even address; a start while busy must be ignored
    w0 = 16'h5A3C;
    exp_q.push_back({1'b1, 32'h0000_005A});
    issue(24'h000010, 2'd0, 1'b1, 3'd1, 32'h0);
    repeat (12) @(negedge sys_clk);
    issue(24'h000011, 2'd1, 1'b0, 3'd3, 32'hFFFF_FFFF);
    wait_idle("byte_rd_even", 400);
    check("busy_start_ignored", obs_done_n, 1);
    check("byte_rd_even_addr", 32'(obs_a[0]), 32'h8);
    check("byte_rd_even_uds_lds", 32'({obs_uds, obs_lds}), 32'h2);

    // Byte read at odd address
    exp_q.push_back({1'b1, 32'h0000_003C});
    issue(24'h000011, 2'd0, 1'b1, 3'd1, 32'h0);
    wait_idle("byte_rd_odd", 400);

    // Reset while waiting for DTACK aborts with no done pulse
    dtk_dly = 0;
    issue(24'h000200, 2'd1, 1'b1, 3'd5, 32'h0);
    n = 0;
    while (nas_out !== 1'b0 && n < 200) begin @(negedge sys_clk); n++; end
    check("rst_test_as_seen", 32'(nas_out), 32'd0);
    repeat (20) @(negedge sys_clk);
    #1 nRST = 1'b0;
    #1;
    check("abort_drives", 32'({abus_drive, dbus_drive, ctrl_drive}), 32'h0);
    check("abort_strobes", 32'({nas_out, nuds_out, nlds_out, rnw_out}), 32'hF);
    check("abort_status", 32'({req_busy, req_terminated_normally}), 32'h0);
    check("abort_rdata", req_data_read, 32'h0);
    repeat (10) @(negedge sys_clk);
    check("abort_no_done", obs_done_n, 0);
    nRST = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Request after the abort runs normally
    dtk_dly = 1; w0 = 16'hCAFE;
    exp_q.push_back({1'b1, 32'h0000_CAFE});
    issue(24'h000400, 2'd3, 1'b1, 3'd6, 32'h0);
    wait_idle("after_abort", 400);
    check("after_abort_addr", 32'(obs_a[0]), 32'h200);

    // No DTACK at all
    dtk_dly = 0;
`ifdef BERR_TIMEOUT_EN
    exp_q.push_back({1'b0, 32'h0000_CAFE});
    issue(24'h000600, 2'd1, 1'b1, 3'd5, 32'h0);
    wait_idle("bus_timeout", 3000);
    check("bus_timeout_done", obs_done_n, 1);
`else
    issue(24'h000600, 2'd1, 1'b1, 3'd5, 32'h0);
    f0 = fall_cnt;
    n = 0;
    while (fall_cnt - f0 < 1000 && n < 9000) begin @(negedge sys_clk); n++; end
    check("no_timeout_busy", 32'(req_busy), 32'd1);
    check("no_timeout_no_done", obs_done_n, 0);
    pulse_reset();
`endif

    repeat (4) @(negedge sys_clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
